// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU, load unit and debug host.
// Registered write stage with one-hot select plus a saturating contention counter.
module reg_write_arbiter #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [2:0]        req_addr0,
  input  logic [2:0]        req_addr1,
  input  logic [2:0]        req_addr2,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [2:0]        wr_addr,
  output logic [7:0]        wr_sel,
  output logic [DATA_W-1:0] wr_data,
  output logic [2:0]        grant,
  output logic [7:0]        conflict_cnt
);

  localparam int unsigned N_REQ = 3;
  localparam int unsigned CNT_W = 8;

  logic [1:0]        r_ptr;
  logic              r_wr_en;
  logic [2:0]        r_wr_addr;
  logic [7:0]        r_wr_sel;
  logic [DATA_W-1:0] r_wr_data;
  logic [2:0]        r_grant;
  logic [CNT_W-1:0]  r_conflict_cnt;

  logic [1:0]        w_win_idx;
  logic              w_win_vld;
  logic [2:0]        w_ready;
  logic [2:0]        w_addr;
  logic [DATA_W-1:0] w_data;
  logic [7:0]        w_sel;
  logic              w_conflict;
  logic [2:0]        w_cand;

  // Search ptr, ptr+1, ptr+2; walking backwards lets the nearest valid requester win.
  always_comb begin
    w_win_idx = r_ptr;
    w_win_vld = 1'b0;
    w_cand    = 3'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = 3'({1'b0, r_ptr}) + 3'(k);
      if (w_cand >= 3'd3) w_cand = w_cand - 3'd3;
      if (req_valid[w_cand[1:0]]) begin
        w_win_idx = w_cand[1:0];
        w_win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_addr = req_addr0;
    w_data = req_data0;
    case (w_win_idx)
      2'd1:    begin w_addr = req_addr1; w_data = req_data1; end
      2'd2:    begin w_addr = req_addr2; w_data = req_data2; end
      default: begin w_addr = req_addr0; w_data = req_data0; end
    endcase
  end

  always_comb begin
    w_ready = 3'd0;
    if (w_win_vld && !wr_stall) w_ready = 3'd1 << w_win_idx;
  end

  // r0 writes are accepted but never strobed when register 0 is hard-wired.
  always_comb begin
    w_sel = 8'd1 << w_addr;
    if ((ZERO_REG != 0) && (w_addr == 3'd0)) w_sel = 8'd0;
  end

  assign w_conflict = (req_valid[0] & req_valid[1]) | (req_valid[0] & req_valid[2]) |
                      (req_valid[1] & req_valid[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr          <= 2'd0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= 3'd0;
      r_wr_sel       <= 8'd0;
      r_wr_data      <= '0;
      r_grant        <= 3'd0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_conflict && (r_conflict_cnt != {CNT_W{1'b1}}))
        r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
      if (!wr_stall) begin
        if (w_win_vld) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_addr;
          r_wr_data <= w_data;
          r_wr_sel  <= w_sel;
          r_grant   <= w_ready;
          r_ptr     <= (w_win_idx == 2'd2) ? 2'd0 : w_win_idx + 2'd1;
        end else begin
          r_wr_en  <= 1'b0;
          r_wr_sel <= 8'd0;
          r_grant  <= 3'd0;
        end
      end
    end
  end

  assign req_ready    = w_ready;
  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_sel       = r_wr_sel;
  assign wr_data      = r_wr_data;
  assign grant        = r_grant;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: two instances (r0 hard-wired and not) on shared stimulus.
module tb_reg_write_arbiter;

  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [2:0]        addr;
    logic [DATA_W-1:0] data;
    logic [2:0]        grant;
  } wr_item_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [2:0]        req_valid = 3'd0;
  logic [2:0]        req_addr [3];
  logic [DATA_W-1:0] req_data [3];
  logic              wr_stall = 1'b0;

  logic [2:0]        rdy_a, rdy_b;
  logic              en_a, en_b;
  logic [2:0]        addr_a, addr_b;
  logic [7:0]        sel_a, sel_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic [2:0]        grant_a, grant_b;
  logic [7:0]        cnt_a, cnt_b;

  always #5 clk = ~clk;

  reg_write_arbiter #(.DATA_W(DATA_W), .ZERO_REG(1)) u_z1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a),
    .req_addr0(req_addr[0]), .req_addr1(req_addr[1]), .req_addr2(req_addr[2]),
    .req_data0(req_data[0]), .req_data1(req_data[1]), .req_data2(req_data[2]),
    .wr_stall(wr_stall), .wr_en(en_a), .wr_addr(addr_a), .wr_sel(sel_a),
    .wr_data(data_a), .grant(grant_a), .conflict_cnt(cnt_a));

  reg_write_arbiter #(.DATA_W(DATA_W), .ZERO_REG(0)) u_z0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b),
    .req_addr0(req_addr[0]), .req_addr1(req_addr[1]), .req_addr2(req_addr[2]),
    .req_data0(req_data[0]), .req_data1(req_data[1]), .req_data2(req_data[2]),
    .wr_stall(wr_stall), .wr_en(en_b), .wr_addr(addr_b), .wr_sel(sel_b),
    .wr_data(data_b), .grant(grant_b), .conflict_cnt(cnt_b));

  int n_pass = 0;
  int n_total = 0;

  wr_item_t          sb_q[$];
  int                m_ptr;
  int                m_cnt;
  logic              m_en;
  logic [2:0]        m_addr;
  logic [DATA_W-1:0] m_data;
  logic [2:0]        m_grant;
  logic              m_xfer;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [2:0] a, input logic [DATA_W-1:0] d);
    req_addr[i] = a;
    req_data[i] = d;
  endtask

  function automatic logic [7:0] exp_sel(input logic en, input logic [2:0] a, input bit zr);
    logic [7:0] s;
    s = en ? (8'd1 << a) : 8'd0;
    if (zr && a == 3'd0) s = 8'd0;
    return s;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".wr_en"},   32'(en_a),    32'(m_en));
    chk({tag, ".grant"},   32'(grant_a), 32'(m_grant));
    chk({tag, ".cnt"},     32'(cnt_a),   32'(m_cnt));
    chk({tag, ".sel_z1"},  32'(sel_a),   32'(exp_sel(m_en, m_addr, 1'b1)));
    chk({tag, ".sel_z0"},  32'(sel_b),   32'(exp_sel(m_en, m_addr, 1'b0)));
    if (m_en) begin
      chk({tag, ".addr"}, 32'(addr_a), 32'(m_addr));
      chk({tag, ".data"}, 32'(data_a), 32'(m_data));
    end
  endtask

  // One clock: drive, check ready before the edge, then check the write stage after it.
  task automatic step(input string tag, input logic [2:0] v, input logic stall);
    int        w;
    int        idx;
    logic [2:0] exp_rdy;
    wr_item_t  it;
    req_valid = v;
    wr_stall  = stall;
    @(negedge clk);
    w = -1;
    for (int k = 2; k >= 0; k--) begin
      idx = (m_ptr + k) % 3;
      if (v[idx]) w = idx;
    end
    exp_rdy = (w >= 0 && !stall) ? (3'd1 << w) : 3'd0;
    chk({tag, ".ready"}, 32'(rdy_a), 32'(exp_rdy));
    m_xfer = (exp_rdy != 3'd0);
    if (m_xfer) begin
      sb_q.push_back('{addr: req_addr[w], data: req_data[w], grant: exp_rdy});
      m_ptr = (w + 1) % 3;
    end
    if (((v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2])) && m_cnt < 255) m_cnt++;
    @(posedge clk);
    #1;
    if (!stall) begin
      if (m_xfer) begin
        if (sb_q.size() == 0) begin
          chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
          it      = sb_q.pop_front();
          m_en    = 1'b1;
          m_addr  = it.addr;
          m_data  = it.data;
          m_grant = it.grant;
        end
      end else begin
        m_en    = 1'b0;
        m_grant = 3'd0;
      end
    end
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag, input logic [2:0] v);
    req_valid = v;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_en    = 1'b0;
    m_grant = 3'd0;
    m_addr  = 3'd0;
    m_data  = '0;
    sb_q.delete();
    check_outputs(tag);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) set_req(i, 3'd0, '0);
    m_ptr = 0; m_cnt = 0; m_en = 1'b0; m_addr = 3'd0; m_data = '0; m_grant = 3'd0;
    @(posedge clk);
    #1;
    do_reset("reset", 3'b000);

    // Single ALU write
    set_req(0, 3'd5, 16'h1234);
    step("alu_single", 3'b001, 1'b0);
    chk("alu_single.sel_lit", 32'(sel_a), 32'h20);
    chk("alu_single.grant_lit", 32'(grant_a), 32'h1);
    step("idle", 3'b000, 1'b0);

    // All three valid, round robin from a fresh pointer
    do_reset("reset_rr", 3'b000);
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 3; i++) set_req(i, 3'(i + 1), 16'(16'hA000 + c * 16 + i));
      step("rr3", 3'b111, 1'b0);
    end
    chk("rr3.cnt_lit", 32'(cnt_a), 32'd6);

    // Load unit writes r0
    set_req(1, 3'd0, 16'hBEEF);
    step("r0_write", 3'b010, 1'b0);
    chk("r0_write.z1_sel", 32'(sel_a), 32'h00);
    chk("r0_write.z0_sel", 32'(sel_b), 32'h01);
    chk("r0_write.z1_en", 32'(en_a), 32'd1);

    // ALU write held by stall while debug waits
    set_req(0, 3'd3, 16'h5A5A);
    set_req(2, 3'd6, 16'hD00D);
    step("stall_alu", 3'b001, 1'b0);
    for (int c = 0; c < 3; c++) step("stall_hold", 3'b100, 1'b1);
    step("stall_release", 3'b100, 1'b0);
    chk("stall_release.grant_lit", 32'(grant_a), 32'h4);

    // Reset while a write is stalled with two requests pending
    set_req(0, 3'd1, 16'h1111);
    set_req(1, 3'd2, 16'h2222);
    set_req(2, 3'd4, 16'h4444);
    step("pre_rst", 3'b011, 1'b0);
    step("pre_rst_stall", 3'b011, 1'b1);
    do_reset("mid_rst", 3'b011);
    step("post_rst", 3'b110, 1'b0);
    chk("post_rst.grant_lit", 32'(grant_a), 32'h2);

    // Long ALU + load contention: counter saturates, grants alternate
    do_reset("reset_sat", 3'b000);
    for (int c = 0; c < 300; c++) begin
      set_req(0, 3'd7, 16'(c));
      set_req(1, 3'd2, 16'(16'h8000 + c));
      step("sat", 3'b011, 1'b0);
    end
    chk("sat.cnt_lit", 32'(cnt_a), 32'd255);

    // Randomised mix of valids, stalls and addresses
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < 3; i++) set_req(i, 3'($urandom_range(0, 7)), 16'($urandom));
      step("rand", 3'($urandom_range(0, 7)), logic'($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
